vga_tile_render: RTL

//  Stage directly downstream of vga_buffer, on the pixel side. Converts the sync

---
 rtl/vga_tile_render.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_tile_render.sv
// Pixel-side tile renderer: maps sync coordinates to tile-buffer addresses and
// decodes the returned tile word into one RGB444 pixel per clock.
module vga_tile_render #(
  parameter int H_TILES     = 40,
  parameter int V_TILES     = 15,
  parameter int TILE_W_LOG2 = 4,
  parameter int TILE_H_LOG2 = 5,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 28,
  parameter bit SYNC_POL    = 1'b0,
  parameter int BLINK_LOG2  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic [ADDR_W-1:0] vr_addr_o,
  input  logic [DATA_W-1:0] tile_i,
  output logic [11:0]       rgb_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              oob_o
);

  localparam int TW = 1 << TILE_W_LOG2;
  localparam int TH = 1 << TILE_H_LOG2;
  localparam logic [10:0] H_PIX = 11'(H_TILES * TW);
  localparam logic [10:0] V_PIX = 11'(V_TILES * TH);

  logic [9:0]             tx, ty;
  logic [ADDR_W-1:0]      addr;
  logic                   in_grid, vis;

  logic [TILE_W_LOG2-1:0] px1, px2;
  logic [TILE_H_LOG2-1:0] py1, py2;
  logic                   de1, de2;
  logic                   hs1, hs2, vs1, vs2;

  logic [BLINK_LOG2-1:0]  frame_cnt;
  logic                   vs_prev, vs_edge, blink_ph;

  logic [11:0]            fg, bg, pix;
  logic                   blink, on;
  logic [2:0]             pat;

  always_comb begin
    tx      = hcount_i >> TILE_W_LOG2;
    ty      = vcount_i >> TILE_H_LOG2;
    addr    = ADDR_W'(ty) * ADDR_W'(H_TILES) + ADDR_W'(tx);
    in_grid = ({1'b0, hcount_i} < H_PIX) && ({1'b0, vcount_i} < V_PIX);
    vis     = de_i & in_grid;
    vs_edge = (vsync_i == SYNC_POL) && (vs_prev != SYNC_POL);
    blink_ph = frame_cnt[BLINK_LOG2-1];
  end

  // tile word: fg | bg | blink | pattern
  always_comb begin
    fg    = tile_i[27:16];
    bg    = tile_i[15:4];
    blink = tile_i[3];
    pat   = tile_i[2:0];
    on    = 1'b0;
    unique case (pat)
      3'd0: on = 1'b0;
      3'd1: on = 1'b1;
      3'd2: on = ~px2[TILE_W_LOG2-1];
      3'd3: on = ~py2[TILE_H_LOG2-1];
      3'd4: on = px2[0] ^ py2[0];
      3'd5: on = (px2 == '0) || (px2 == '1) ||
                 (py2 == '0) || (py2 == '1);
      3'd6: on = (px2 == py2[TILE_W_LOG2-1:0]);
      3'd7: on = (py2[TILE_H_LOG2-1:1] == '1);
    endcase
    if (!de2)
      pix = 12'h000;
    else if (blink && blink_ph)
      pix = bg;
    else
      pix = on ? fg : bg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vr_addr_o <= '0;
      px1       <= '0;
      py1       <= '0;
      de1       <= 1'b0;
      hs1       <= ~SYNC_POL;
      vs1       <= ~SYNC_POL;
      px2       <= '0;
      py2       <= '0;
      de2       <= 1'b0;
      hs2       <= ~SYNC_POL;
      vs2       <= ~SYNC_POL;
      rgb_o     <= 12'h000;
      de_o      <= 1'b0;
      hsync_o   <= ~SYNC_POL;
      vsync_o   <= ~SYNC_POL;
      oob_o     <= 1'b0;
      frame_cnt <= '0;
      vs_prev   <= ~SYNC_POL;
    end else begin
      vr_addr_o <= vis ? addr : '0;
      px1       <= hcount_i[TILE_W_LOG2-1:0];
      py1       <= vcount_i[TILE_H_LOG2-1:0];
      de1       <= vis;
      hs1       <= hsync_i;
      vs1       <= vsync_i;
      // stage 2 waits out the buffer read latency
      px2       <= px1;
      py2       <= py1;
      de2       <= de1;
      hs2       <= hs1;
      vs2       <= vs1;
      rgb_o     <= pix;
      de_o      <= de2;
      hsync_o   <= hs2;
      vsync_o   <= vs2;
      if (de_i && !in_grid)
        oob_o <= 1'b1;
      vs_prev   <= vsync_i;
      if (vs_edge)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
